// File: rtl/cpu_pkg.sv
// Shared widths, opcode encoding and the decode-to-execute register layout for the core.
// Types only: no latency or flow control.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int NREG   = 16;
    localparam int REG_W  = $clog2(NREG);

    typedef logic [DATA_W-1:0] block_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [31:0]       inst_t;
    typedef logic [REG_W-1:0]  reg_idx_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_GT   = 4'd5,
        OP_EQ   = 4'd6,
        OP_ADDI = 4'd7,
        OP_LD   = 4'd8,
        OP_ST   = 4'd9,
        OP_BNZ  = 4'd10,
        OP_JMP  = 4'd11,
        OP_HALT = 4'd12
    } opcode_e;

    // b holds rt for register ops and the sign-extended immediate for ADDI/LD/ST.
    typedef struct packed {
        logic     vld;
        reg_idx_t rd;
        block_t   a;
        block_t   b;
        block_t   st_dat;
        addr_t    target;
        logic     is_add;
        logic     is_sub;
        logic     is_and;
        logic     is_or;
        logic     is_gt;
        logic     is_eq;
        logic     is_mem_read;
        logic     is_mem_write;
        logic     is_reg_write;
        logic     is_branch;
        logic     is_jump;
        logic     is_halt;
    } id_ex_t;
endpackage

// File: rtl/fetch_decode_execute_if.sv
// Core-to-memory bus: instruction ROM fetch, data RAM access and halt status.
// Both memories answer combinationally in the same cycle; no backpressure.
interface fetch_decode_execute_if;
    import cpu_pkg::*;

    addr_t  imem_addr;
    inst_t  imem_data;
    addr_t  dmem_addr;
    block_t dmem_wdata;
    logic   dmem_we;
    block_t dmem_rdata;
    logic   do_halt;

    modport master (
        output imem_addr, dmem_addr, dmem_wdata, dmem_we, do_halt,
        input  imem_data, dmem_rdata
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we, do_halt,
        output imem_data, dmem_rdata
    );
endinterface

// File: rtl/regfile.sv
// Register file: two combinational read ports, one write port committed at the clock edge.
// r0 always reads zero; reset clears every entry; no backpressure.
module regfile
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rs_idx,
    input  reg_idx_t rt_idx,
    output block_t   rs_dat,
    output block_t   rt_dat,
    input  logic     wr_vld,
    input  reg_idx_t wr_idx,
    input  block_t   wr_dat
);
    block_t regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_vld && wr_idx != '0) begin
            regs[wr_idx] <= wr_dat;
        end
    end

    assign rs_dat = (rs_idx == '0) ? '0 : regs[rs_idx];
    assign rt_dat = (rt_idx == '0) ? '0 : regs[rt_idx];
endmodule

// File: rtl/fetch_decode_execute.sv
// Three-stage in-order core (fetch, decode, execute); instructions retire 3 cycles after fetch.
// No stalls: EX-to-ID bypass covers dependents, taken branches/jumps squash 2 slots, HALT freezes.
module fetch_decode_execute
    import cpu_pkg::*;
(
    input logic                    clk,
    input logic                    rst,
    fetch_decode_execute_if.master bus
);
    addr_t    pc;
    inst_t    ifid_inst;
    logic     ifid_vld;
    id_ex_t   idex;
    id_ex_t   id_nxt;
    logic     halted;

    logic [3:0]  op;
    reg_idx_t    rd_f, rs_f, rt_f;
    logic [15:0] imm_f;
    block_t      imm_sx;
    block_t      rf_rs, rf_rt, rs_val, rt_val;

    block_t ex_sum, ex_res;
    logic   ex_go, ex_wr, ex_take, halt_now, freeze;

    assign op     = ifid_inst[31:28];
    assign rd_f   = ifid_inst[27:24];
    assign rs_f   = ifid_inst[23:20];
    assign rt_f   = ifid_inst[19:16];
    assign imm_f  = ifid_inst[15:0];
    assign imm_sx = {{(DATA_W-16){imm_f[15]}}, imm_f};

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .rs_idx (rs_f),
        .rt_idx (rt_f),
        .rs_dat (rf_rs),
        .rt_dat (rf_rt),
        .wr_vld (ex_wr),
        .wr_idx (idex.rd),
        .wr_dat (ex_res)
    );

    // The result being written this cycle is not yet in the register file, so bypass it.
    assign rs_val = (ex_wr && idex.rd == rs_f) ? ex_res : rf_rs;
    assign rt_val = (ex_wr && idex.rd == rt_f) ? ex_res : rf_rt;

    always_comb begin
        id_nxt        = '0;
        id_nxt.vld    = ifid_vld;
        id_nxt.rd     = rd_f;
        id_nxt.a      = rs_val;
        id_nxt.b      = rt_val;
        id_nxt.st_dat = rt_val;
        id_nxt.target = imm_f[ADDR_W-1:0];
        case (op)
            OP_ADD:  begin id_nxt.is_add = 1'b1; id_nxt.is_reg_write = 1'b1; end
            OP_SUB:  begin id_nxt.is_sub = 1'b1; id_nxt.is_reg_write = 1'b1; end
            OP_AND:  begin id_nxt.is_and = 1'b1; id_nxt.is_reg_write = 1'b1; end
            OP_OR:   begin id_nxt.is_or  = 1'b1; id_nxt.is_reg_write = 1'b1; end
            OP_GT:   begin id_nxt.is_gt  = 1'b1; id_nxt.is_reg_write = 1'b1; end
            OP_EQ:   begin id_nxt.is_eq  = 1'b1; id_nxt.is_reg_write = 1'b1; end
            OP_ADDI: begin
                id_nxt.is_add       = 1'b1;
                id_nxt.is_reg_write = 1'b1;
                id_nxt.b            = imm_sx;
            end
            OP_LD: begin
                id_nxt.is_mem_read  = 1'b1;
                id_nxt.is_reg_write = 1'b1;
                id_nxt.b            = imm_sx;
            end
            OP_ST: begin
                id_nxt.is_mem_write = 1'b1;
                id_nxt.b            = imm_sx;
            end
            OP_BNZ:  id_nxt.is_branch = 1'b1;
            OP_JMP:  id_nxt.is_jump   = 1'b1;
            OP_HALT: id_nxt.is_halt   = 1'b1;
            default: ;
        endcase
    end

    assign ex_go    = idex.vld && !halted;
    assign ex_wr    = ex_go && idex.is_reg_write && idex.rd != '0;
    assign ex_take  = ex_go && (idex.is_jump || (idex.is_branch && idex.a != '0));
    assign halt_now = ex_go && idex.is_halt;
    assign freeze   = halted || halt_now;
    assign ex_sum   = idex.a + idex.b;

    always_comb begin
        ex_res = '0;
        if (idex.is_add)           ex_res = ex_sum;
        else if (idex.is_sub)      ex_res = idex.a - idex.b;
        else if (idex.is_and)      ex_res = idex.a & idex.b;
        else if (idex.is_or)       ex_res = idex.a | idex.b;
        else if (idex.is_gt)       ex_res = {{(DATA_W-1){1'b0}}, idex.a > idex.b};
        else if (idex.is_eq)       ex_res = {{(DATA_W-1){1'b0}}, idex.a == idex.b};
        else if (idex.is_mem_read) ex_res = bus.dmem_rdata;
    end

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = ex_sum[ADDR_W-1:0];
    assign bus.dmem_wdata = idex.st_dat;
    assign bus.dmem_we    = rst && ex_go && idex.is_mem_write;
    assign bus.do_halt    = halted;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= '0;
            ifid_inst <= '0;
            ifid_vld  <= 1'b0;
            idex      <= '0;
            halted    <= 1'b0;
        end else begin
            if (halt_now) begin
                halted <= 1'b1;
            end
            if (!freeze) begin
                if (ex_take) begin
                    pc       <= idex.target;
                    ifid_vld <= 1'b0;
                    idex     <= '0;
                end else begin
                    pc        <= pc + addr_t'(1);
                    ifid_inst <= bus.imem_data;
                    ifid_vld  <= 1'b1;
                    idex      <= id_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_decode_execute.sv
// Bench for the three-stage core: directed programs plus random forward-branching programs,
// with every data-memory store checked in order against an instruction-level reference model.
module tb_fetch_decode_execute;
    import cpu_pkg::*;

    typedef struct packed {
        addr_t  a;
        block_t d;
    } store_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_decode_execute_if bus ();

    fetch_decode_execute dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    inst_t  rom      [256];
    block_t ram      [256];
    block_t ram_init [256];
    addr_t  trace    [300];
    store_t exp_q    [$];
    int     n_vec = 0;
    int     n_bad = 0;

    assign bus.imem_data  = rom[bus.imem_addr];
    assign bus.dmem_rdata = ram[bus.dmem_addr];

    // RAM is reloaded from ram_init while reset is held.
    always @(posedge clk) begin
        if (!rst) ram <= ram_init;
        else if (bus.dmem_we === 1'b1) ram[bus.dmem_addr] <= bus.dmem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        store_t e;
        if (rst && bus.dmem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL store_unexpected: got addr %h data %h, want no store",
                         bus.dmem_addr, bus.dmem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("store_addr", 32'(bus.dmem_addr), 32'(e.a));
                check("store_data", bus.dmem_wdata, e.d);
            end
        end
    end

    function automatic inst_t mk(input logic [3:0] op, input logic [3:0] rd,
                                 input logic [3:0] rs, input logic [3:0] rt,
                                 input logic [15:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic expect_st(input addr_t a, input block_t d);
        exp_q.push_back(store_t'({a, d}));
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = '0;
    endtask

    task automatic start();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", 32'(bus.imem_addr), 32'd0);
        check("rst_halt", 32'(bus.do_halt), 32'd0);
        check("rst_we", 32'(bus.dmem_we), 32'd0);
        rst = 1'b1;
    endtask

    // trace[k-1] holds imem_addr after the k-th edge following reset release.
    task automatic run_prog(input string tag, output int cyc);
        start();
        cyc = 0;
        while (bus.do_halt !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            @(negedge clk);
            trace[cyc] = bus.imem_addr;
            cyc++;
        end
        check({tag, "_halted"}, 32'(bus.do_halt), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_halt_sticky"}, 32'(bus.do_halt), 32'd1);
        check({tag, "_we_frozen"}, 32'(bus.dmem_we), 32'd0);
        check({tag, "_stores_done"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Instruction-at-a-time interpreter of the ISA; records the stores a program makes.
    task automatic model_run();
        block_t     r [NREG];
        block_t     m [256];
        addr_t      pc;
        inst_t      ins;
        block_t     a, b, sx, res;
        addr_t      ea;
        logic [3:0] op, rd;
        bit         wr;
        r  = '{default: '0};
        m  = ram_init;
        pc = '0;
        for (int step = 0; step < 2000; step++) begin
            ins = rom[pc];
            op  = ins[31:28];
            rd  = ins[27:24];
            a   = r[ins[23:20]];
            b   = r[ins[19:16]];
            sx  = {{16{ins[15]}}, ins[15:0]};
            ea  = addr_t'(a + sx);
            pc  = pc + 8'd1;
            wr  = 1'b1;
            res = '0;
            case (op)
                OP_ADD:  res = a + b;
                OP_SUB:  res = a - b;
                OP_AND:  res = a & b;
                OP_OR:   res = a | b;
                OP_GT:   res = (a > b) ? 32'd1 : 32'd0;
                OP_EQ:   res = (a == b) ? 32'd1 : 32'd0;
                OP_ADDI: res = a + sx;
                OP_LD:   res = m[ea];
                OP_ST: begin
                    wr = 1'b0;
                    m[ea] = b;
                    expect_st(ea, b);
                end
                OP_BNZ: begin
                    wr = 1'b0;
                    if (a != 0) pc = ins[7:0];
                end
                OP_JMP: begin
                    wr = 1'b0;
                    pc = ins[7:0];
                end
                OP_HALT: return;
                default: wr = 1'b0;
            endcase
            if (wr && rd != 0) r[rd] = res;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int cyc;
        int len;
        int k;
        logic [15:0] imm;
        clear_rom();
        foreach (ram_init[i]) ram_init[i] = '0;

        // Straight line to HALT: exact halt latency and frozen PC.
        rom[0] = mk(OP_ADDI, 1, 0, 0, 16'd5);
        rom[1] = mk(OP_ADDI, 2, 0, 0, 16'd7);
        rom[2] = mk(OP_ADD,  3, 1, 2, 16'd0);
        rom[3] = mk(OP_HALT, 0, 0, 0, 16'd0);
        run_prog("halt_seq", cyc);
        check("halt_latency", 32'(cyc), 32'd6);
        check("pc_frozen", 32'(bus.imem_addr), 32'd5);

        // Same program, exposing r3.
        rom[3] = mk(OP_ST,   0, 0, 3, 16'd0);
        rom[4] = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd0, 32'd12);
        run_prog("add_r3", cyc);

        // Back-to-back dependent chain through the bypass.
        clear_rom();
        rom[0] = mk(OP_ADDI, 1, 0, 0, 16'd1);
        for (int i = 1; i <= 4; i++) rom[i] = mk(OP_ADD, 1, 1, 1, 16'd0);
        rom[5] = mk(OP_ST,   0, 0, 1, 16'd1);
        rom[6] = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd1, 32'd16);
        run_prog("fwd_chain", cyc);

        // Store then load of the same word.
        clear_rom();
        ram_init[3] = 32'h55;
        rom[0] = mk(OP_ADDI, 1, 0, 0, 16'hAB);
        rom[1] = mk(OP_ST,   0, 0, 1, 16'd3);
        rom[2] = mk(OP_LD,   4, 0, 0, 16'd3);
        rom[3] = mk(OP_ST,   0, 0, 4, 16'd4);
        rom[4] = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd3, 32'hAB);
        expect_st(8'd4, 32'hAB);
        run_prog("st_ld", cyc);

        // Taken branch: both slots squashed, fetch resumes at 10.
        clear_rom();
        rom[0]  = mk(OP_ADDI, 1, 0, 0, 16'd1);
        rom[1]  = mk(OP_BNZ,  0, 1, 0, 16'd10);
        rom[2]  = mk(OP_ADDI, 5, 0, 0, 16'd9);
        rom[3]  = mk(OP_ADDI, 5, 0, 0, 16'd9);
        rom[10] = mk(OP_ST,   0, 0, 5, 16'd5);
        rom[11] = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd5, 32'd0);
        run_prog("bnz_taken", cyc);
        check("bnz_taken_pc_before", 32'(trace[2]), 32'd3);
        check("bnz_taken_redirect", 32'(trace[3]), 32'd10);
        check("bnz_taken_halt_cyc", 32'(cyc), 32'd8);

        // Not-taken branch: straight fall-through with no bubble.
        rom[0] = mk(OP_ADDI, 1, 0, 0, 16'd0);
        rom[4] = mk(OP_ST,   0, 0, 5, 16'd5);
        rom[5] = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd5, 32'd9);
        run_prog("bnz_not_taken", cyc);
        check("bnz_nt_pc", 32'(trace[3]), 32'd4);
        check("bnz_nt_halt_cyc", 32'(cyc), 32'd8);

        // Compare ops and wrapping subtract.
        clear_rom();
        rom[0] = mk(OP_ADDI, 1, 0, 0, 16'd3);
        rom[1] = mk(OP_ADDI, 2, 0, 0, 16'd3);
        rom[2] = mk(OP_GT,   6, 1, 2, 16'd0);
        rom[3] = mk(OP_EQ,   7, 1, 2, 16'd0);
        rom[4] = mk(OP_SUB,  8, 0, 1, 16'd0);
        rom[5] = mk(OP_ST,   0, 0, 6, 16'd6);
        rom[6] = mk(OP_ST,   0, 0, 7, 16'd7);
        rom[7] = mk(OP_ST,   0, 0, 8, 16'd8);
        rom[8] = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd6, 32'd0);
        expect_st(8'd7, 32'd1);
        expect_st(8'd8, 32'hFFFF_FFFD);
        run_prog("cmp_sub", cyc);

        // PC wraps from 255 to 0; the second pass through 0 branches away.
        clear_rom();
        rom[0]   = mk(OP_BNZ,  0, 1, 0, 16'd5);
        rom[1]   = mk(OP_JMP,  0, 0, 0, 16'd254);
        rom[254] = mk(OP_ADDI, 1, 0, 0, 16'h5A);
        rom[255] = mk(OP_ADDI, 2, 0, 0, 16'h33);
        rom[5]   = mk(OP_ST,   0, 0, 2, 16'd2);
        rom[6]   = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd2, 32'h33);
        run_prog("pc_wrap", cyc);
        check("pc_wrap_jmp", 32'(trace[3]), 32'd254);
        check("pc_wrap_zero", 32'(trace[5]), 32'd0);

        // Reset mid-program after r1 has been written; r1 must read 0 again afterwards.
        clear_rom();
        rom[0] = mk(OP_ST,   0, 0, 1, 16'd1);
        rom[1] = mk(OP_ADDI, 1, 0, 0, 16'h11);
        rom[2] = mk(OP_ADDI, 1, 1, 0, 16'd1);
        rom[5] = mk(OP_ST,   0, 0, 1, 16'd1);
        rom[6] = mk(OP_HALT, 0, 0, 0, 16'd0);
        expect_st(8'd1, 32'd0);
        start();
        repeat (4) @(posedge clk);
        check("mid_rst_first_store", 32'(exp_q.size()), 32'd0);
        expect_st(8'd1, 32'd0);
        expect_st(8'd1, 32'h12);
        run_prog("mid_rst", cyc);

        // Random programs with forward-only control flow, then a dump of r1..r7.
        for (int t = 0; t < 25; t++) begin
            clear_rom();
            foreach (ram_init[i]) ram_init[i] = $urandom();
            len = $urandom_range(8, 40);
            for (int i = 0; i < len; i++) begin
                k   = $urandom_range(0, 15);
                imm = 16'($urandom());
                if (k == 12) k = 7;
                if (k == 10 || k == 11) imm = {imm[15:8], 8'($urandom_range(i + 1, len))};
                rom[i] = mk(4'(k), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                            4'($urandom_range(0, 7)), imm);
            end
            for (int r = 1; r <= 7; r++) rom[len + r - 1] = mk(OP_ST, 0, 0, 4'(r), 16'(8'hF0 + r));
            rom[len + 7] = mk(OP_HALT, 0, 0, 0, 16'd0);
            model_run();
            run_prog("rand", cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_decode_execute.md
Name: fetch_decode_execute

Overview:
- Three-stage in-order integer core: Fetch (PC plus IF/ID register), Decode (register file read, control decode, ID/EX register), Execute (ALU, data-memory access, writeback, branch/jump resolution, halt).
- Sits inside the CPU top level, between the external instruction ROM and data RAM.
- Both memories are outside this block and have combinational reads.

Parameters:
- DATA_W, 32, register and data-memory word width.
- ADDR_W, 8, width of the instruction and data address spaces.
- NREG, 16, number of architectural registers (register index is 4 bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- imem_addr  out  ADDR_W  fetch address; always equals the PC.
- imem_data  in  32  instruction at imem_addr, valid in the same cycle.
- dmem_addr  out  ADDR_W  data address from the Execute stage.
- dmem_wdata  out  DATA_W  store data.
- dmem_we  out  1  write strobe; the RAM writes on the clk edge while this is high.
- dmem_rdata  in  DATA_W  load data for dmem_addr, valid in the same cycle.
- do_halt  out  1  high once a HALT has executed; sticky until reset.

Behaviour:
- Instruction fields (32 bits): op = bits 31:28, rd = bits 27:24, rs = bits 23:20, rt = bits 19:16, imm = bits 15:0.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd = rs + rt.
  - 2 SUB: rd = rs - rt.
  - 3 AND: rd = rs & rt.
  - 4 OR: rd = rs | rt.
  - 5 GT: rd = (rs > rt, unsigned) ? 1 : 0.
  - 6 EQ: rd = (rs == rt) ? 1 : 0.
  - 7 ADDI: rd = rs + sign-extended imm.
  - 8 LD: rd = mem[rs + imm].
  - 9 ST: mem[rs + imm] = rt.
  - 10 BNZ: if rs != 0 then PC = imm.
  - 11 JMP: PC = imm.
  - 12 HALT.
  - 13 to 15: treated as NOP.
- Arithmetic wraps modulo 2^DATA_W.
- Memory addresses and branch targets are truncated to ADDR_W bits (addresses wrap).
- Register 0 always reads as 0; writes to it are discarded.
- Reset, on a clk edge with rst = 0:
  - PC = 0.
  - IF/ID and ID/EX valid bits = 0.
  - do_halt = 0.
  - All registers = 0.
  - dmem_we = 0.
- Fetch:
  - Each cycle, IF/ID captures imem_data with valid = 1, and PC increments by 1, wrapping at 2^ADDR_W.
- Decode:
  - Reads rs and rt from the register file.
  - Forwarding: if the instruction currently in Execute writes the same non-zero register, Decode uses that instruction's result (write-through bypass), so back-to-back dependents need no stall.
  - Latches operands and control bits (is_add, is_sub, is_and, is_or, is_gt, is_eq, is_mem_read, is_mem_write, is_reg_write, is_branch, is_jump, is_halt) into ID/EX.
- Execute, for a valid instruction:
  - Computes the result.
  - For LD, the result is dmem_rdata.
  - Writes rd at the clk edge when is_reg_write is set.
  - dmem_we = valid && is_mem_write; it is combinational from ID/EX.
- Redirect:
  - A taken BNZ, or any JMP, in Execute sets PC = imm at the next edge and clears both valid bits.
  - This gives a 2-cycle penalty; a not-taken BNZ has no penalty.
  - The two squashed instructions never write a register or memory.
- Halt:
  - When HALT is valid in Execute, do_halt = 1 from the next edge onward.
  - Afterwards, PC, the pipeline registers, the register file and memory are frozen, and dmem_we = 0.
  - Only reset clears do_halt.
- Simultaneous events:
  - Reset overrides everything.
  - Redirect overrides the PC increment.
  - HALT in Execute blocks any younger instruction from executing.
- PC wrap: PC at 2^ADDR_W - 1 increments to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - typedefs block (DATA_W), addr (ADDR_W) and inst (32 bits).
  - The opcode enum.
  - The NREG constant.
  - An id_ex_t struct for the decode-to-execute register.
- One natural sub-module: regfile, with 2 combinational read ports, 1 synchronous write port, and r0 hardwired to zero.
- Fetch, Decode and Execute logic stay in the top block.

Test Plan:
- ROM = ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT.
  - Required: r3 = 12.
  - do_halt rises 6 cycles after reset release and stays high.
- Dependent chain ADDI r1,r0,1 followed by 4 × ADD r1,r1,r1 with no NOPs.
  - Required: r1 = 16, which exercises forwarding.
- ST r1 to address 3 (r1 = 0xAB, rs = r0, imm = 3), then LD r4,r0,3.
  - Required: dmem_we pulses exactly once with addr 3 and wdata 0xAB; r4 = 0xAB.
- BNZ with r1 = 1 to address 10, where the two slots after the branch hold ADDI r5,r0,9.
  - Required: r5 remains 0, and the next imem_addr after the redirect is 10.
  - Repeating with r1 = 0 falls through with no bubble.
- GT/EQ with r1 = 3, r2 = 3: GT r6,r1,r2 gives 0; EQ r7,r1,r2 gives 1; SUB r8,r0,r1 gives 0xFFFFFFFD.
- Reset driven low mid-program after several ADDIs.
  - Required: all registers return to 0, PC = 0, do_halt = 0.
  - Execution restarts from address 0.
